// File: rtl/mips_pkg.sv
// mips_pkg: shared types and sizes for the boot-load sequencer.
//   load_state_t : sequencer states
//   MEM_DEPTH    : words per memory (data and instruction)
//   WORD_W       : word width
//   MEM_AW       : memory address width, clog2(MEM_DEPTH)
package mips_pkg;

  localparam int MEM_DEPTH = 512;
  localparam int WORD_W    = 32;
  localparam int MEM_AW    = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_D,
    LOAD_I,
    DRAIN,
    CPURST,
    RUN
  } load_state_t;

endpackage

// File: rtl/load_ctrl_if.sv
// load_ctrl_if: serial load port plus memory write bus and CPU control lines.
//   Jen/Jin        : load enable and load word (into the sequencer)
//   Jout           : Jin delayed one clock (daisy chain)
//   dmem_we/imem_we: write strobes, mem_addr/mem_wdata shared by both memories
//   cpu_hold/cpu_rst, load_done/load_err, csum : status and CPU control
// master = the sequencer, slave = the surrounding system.
interface load_ctrl_if #(
  parameter int AW = mips_pkg::MEM_AW,
  parameter int DW = mips_pkg::WORD_W
) ();

  logic          Jen;
  logic [DW-1:0] Jin;
  logic [DW-1:0] Jout;
  logic          dmem_we;
  logic          imem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_hold;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [DW-1:0] csum;

  modport master (
    input  Jen, Jin,
    output Jout, dmem_we, imem_we, mem_addr, mem_wdata,
           cpu_hold, cpu_rst, load_done, load_err, csum
  );

  modport slave (
    output Jen, Jin,
    input  Jout, dmem_we, imem_we, mem_addr, mem_wdata,
           cpu_hold, cpu_rst, load_done, load_err, csum
  );

endinterface

// File: rtl/load_addr_cnt.sv
// load_addr_cnt: loadable down-counter with terminal-count flag.
//   clk, rst (async, active-low) : clock and reset (count resets to INIT)
//   load, load_val               : synchronous load (has priority over dec)
//   dec                          : decrement by one
//   count, tc                    : current value, tc=1 when count==0
module load_addr_cnt #(
  parameter int AW = mips_pkg::MEM_AW,
  parameter logic [AW-1:0] INIT = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] count,
  output logic          tc
);

  logic [AW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= INIT;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == '0);

endmodule

// File: rtl/load_ctrl.sv
// load_ctrl: boot-load sequencer. Streams DEPTH data words then DEPTH
// instruction words (highest address first) into the memories, holds the
// CPU while loading, then pulses cpu_rst for RST_CYCLES clocks and releases.
//   clk, rst (async, active-low)
//   bus (load_ctrl_if.master): Jen/Jin in; Jout, strobes, address/data,
//        cpu_hold, cpu_rst, load_done, load_err, csum out.
// Optional feature macro LOAD_CTRL_CSUM_EN: csum = wrapping sum of the
// captured load words (frozen after the load); otherwise csum is tied to 0.
module load_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH      = MEM_DEPTH,
  parameter int AW         = MEM_AW,
  parameter int DW         = WORD_W,
  parameter int RST_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  load_ctrl_if.master bus
);

  localparam logic [AW-1:0] TOP_ADDR = AW'(DEPTH - 1);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);

  load_state_t   state_reg, state_next;
  logic          dwe_reg, dwe_next;
  logic          iwe_reg, iwe_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [RCW-1:0] rc_reg, rc_next;
  logic [DW-1:0] jout_reg;

  logic          capture;
  logic [AW-1:0] cnt;
  logic          cnt_tc;

  // A word is taken on every Jen=1 clock except while draining an overrun.
  assign capture = bus.Jen && (state_reg != DRAIN);

  // The counter always holds the address for the next captured word: it sits
  // at TOP_ADDR whenever nothing is captured, and wraps back to TOP_ADDR when
  // address 0 is taken so the instruction pass starts at the top again.
  load_addr_cnt #(.AW(AW), .INIT(TOP_ADDR)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!capture || cnt_tc),
    .dec      (capture && !cnt_tc),
    .load_val (TOP_ADDR),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      dwe_reg   <= 1'b0;
      iwe_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rc_reg    <= '0;
      jout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dwe_reg   <= dwe_next;
      iwe_reg   <= iwe_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rc_reg    <= rc_next;
      jout_reg  <= bus.Jin;
    end
  end

  always_comb begin
    state_next = state_reg;
    dwe_next   = 1'b0;
    iwe_next   = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    rc_next    = rc_reg;

    if (capture) begin
      addr_next  = cnt;
      wdata_next = bus.Jin;
    end

    case (state_reg)
      IDLE, CPURST, RUN: begin
        if (bus.Jen) begin
          // New load: first word lands in data memory on this same edge.
          state_next = LOAD_D;
          dwe_next   = 1'b1;
          done_next  = 1'b0;
          err_next   = 1'b0;
        end else if (state_reg == CPURST) begin
          if (rc_reg == RC_LAST) begin
            state_next = RUN;
          end else begin
            rc_next = rc_reg + 1'b1;
          end
        end
      end
      LOAD_D: begin
        if (bus.Jen) begin
          dwe_next = 1'b1;
          if (cnt_tc) state_next = LOAD_I;
        end else begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      LOAD_I: begin
        if (bus.Jen) begin
          iwe_next = 1'b1;
          if (cnt_tc) begin
            state_next = DRAIN;
            done_next  = 1'b1;
          end
        end else begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      DRAIN: begin
        if (!bus.Jen) begin
          state_next = CPURST;
          rc_next    = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef LOAD_CTRL_CSUM_EN
  logic [DW-1:0] csum_reg, csum_next;
  logic          start;

  assign start = capture && (state_reg != LOAD_D) && (state_reg != LOAD_I);

  // Restart seeds the sum with the first word; DRAIN never captures, so the
  // sum stays frozen once the load has completed.
  always_comb begin
    csum_next = csum_reg;
    if (capture) csum_next = (start ? '0 : csum_reg) + bus.Jin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_reg <= '0;
    else      csum_reg <= csum_next;
  end

  assign bus.csum = csum_reg;
`else
  assign bus.csum = '0;
`endif

  assign bus.Jout      = jout_reg;
  assign bus.dmem_we   = dwe_reg;
  assign bus.imem_we   = iwe_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.load_done = done_reg;
  assign bus.load_err  = err_reg;
  assign bus.cpu_hold  = (state_reg != RUN);
  assign bus.cpu_rst   = (state_reg == CPURST);

endmodule
